sum_job_responder: RTL and testbench
====================================

# sum_job_responder

Responder-side controller for the `start`/`done` job handshake used by the top-level test environment. Accepts a one-cycle `start` pulse, reads `N_WORDS` words from a synchronous-read memory, accumulates their sum, writes the result through a one-cycle write strobe and answers with a one-cycle `done` pulse. It is the hardware end that a stimulus driver or sequencer talks to.

## Interface
- `N_WORDS`, 16, words per job; power of two, ≥ 2
- `ADDR_W`, 4, memory address width; `2**ADDR_W == N_WORDS`
- `DATA_W`, 16, memory word width; result width is `DATA_W+ADDR_W`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  job request, sampled every edge
- `done`  out  1  one-cycle job-complete pulse
- `busy`  out  1  high in every state except IDLE
- `mem_rd`  out  1  memory read enable
- `mem_addr`  out  ADDR_W  read address
- `mem_rdata`  in  DATA_W  read data, valid the cycle after the `mem_rd` edge
- `res_wr`  out  1  one-cycle result write strobe
- `res_data`  out  DATA_W+ADDR_W  result; registered, holds its value until the next write

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: if `start`=1 at an edge, clear the accumulator and the address counter, then go to READ.
- READ: `mem_rd`=1 and `mem_addr`=counter; the counter increments each edge.
  - After the edge that issues address `N_WORDS-1`, go to DRAIN.
  - The counter wraps to 0 and is never observed past the last address.
- Read-valid flag is `mem_rd` delayed one edge. On each edge where the flag is 1, the accumulator adds zero-extended `mem_rdata`. The sum is exact; overflow is impossible by width.
- DRAIN: `mem_rd`=0 for one cycle while the last word is accumulated; then go to WRITE.
- WRITE: `res_wr`=1 and `res_data`=accumulator for exactly one cycle; then go to DONE.
- DONE: `done`=1 for one cycle; then go to IDLE. See Configuration for the queued-start variant.
- `start` outside IDLE: behaviour is given under Configuration.
- Reset values: `done`=0, `busy`=0, `mem_rd`=0, `mem_addr`=0, `res_wr`=0, `res_data`=0, accumulator=0, FSM=IDLE.
- Reset mid-job: the job aborts at the next edge. No `res_wr` and no `done` are issued for it, and `res_data` returns to 0.
- `rst` and `start` high at the same edge: reset wins and the job is not accepted.

## Timing
- Edge E0 samples `start`.
- `mem_rd` is high during the cycles after edges E0 … E0+N_WORDS-1, with addresses 0 … N_WORDS-1 in order.
- DRAIN is the cycle after edge E0+N_WORDS.
- `res_wr` is high in the cycle after edge E0+N_WORDS+1.
- `done` is high in the cycle after edge E0+N_WORDS+2. With the default parameters this is 18 cycles after E0.
- `busy` rises after E0 and falls after edge E0+N_WORDS+3.
- Back-to-back jobs without the queue feature: a new `start` is accepted no earlier than the first IDLE cycle.

## Configuration
- Macro `START_QUEUE_EN`.
- Defined:
  - A `start` seen while `busy`=1 sets a one-deep pending flag; further starts while the flag is set are dropped.
  - On leaving DONE with the flag set, the FSM clears the flag, accumulator and counter and goes directly to READ, skipping IDLE.
  - The next `mem_rd` appears in the cycle immediately after the `done` cycle.
  - Reset clears the flag.
- Undefined: `start` while `busy`=1 is ignored entirely.

## Structure
- Shared package `sum_job_pkg`:
  - state encoding constants for IDLE/READ/DRAIN/WRITE/DONE
  - default `N_WORDS`/`ADDR_W`/`DATA_W` values
  - result-width expression
- One sub-module, `word_accumulator`:
  - holds the read-valid delay flag and the `DATA_W+ADDR_W` accumulator
  - synchronous clear input
- The top level holds the FSM, the address counter and the optional pending flag.

## Test plan
- Memory holds 1 … 16, single `start` -> addresses 0 … 15 on consecutive cycles; `res_wr` with `res_data`=136; `done` 18 cycles after E0; `busy` low afterwards.
- All 16 words = 16'hFFFF -> `res_data`=20'hFFFF0 (no overflow). Then all words = 0 -> `res_data`=0.
- `rst` pulsed at cycle 8 of a job -> next edge gives all outputs at reset values; no `res_wr`/`done`. A fresh `start` then produces a normal result.
- `start` held high for 3 cycles -> exactly one job runs (macro undefined).
- With `START_QUEUE_EN`, `start` pulsed at cycles 5 and 7 of a job -> exactly two jobs; the second job's `mem_rd` begins the cycle after the first `done`; two `done` pulses in total.
- `rst` and `start` asserted at the same edge -> nothing starts; `busy` stays 0.

Source files
------------

// File: rtl/sum_job_pkg.sv
// Shared definitions for the sum job responder: FSM encoding, default sizes,
// and the result-width rule.
package sum_job_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_N_WORDS = 16;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 16;

    // Sum of 2**addr_w words of data_w bits never exceeds data_w+addr_w bits.
    function automatic int res_width(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

endpackage

// File: rtl/sum_job_responder_word_accumulator.sv
// Accumulates memory read data one cycle after each read strobe.
// sum_next exposes the value the accumulator takes at the coming edge.
module word_accumulator #(
    parameter int DATA_W = 16,
    parameter int SUM_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd,
    input  logic [DATA_W-1:0] rdata,
    output logic [SUM_W-1:0]  sum_next
);

    logic             rd_vld;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum_next = sum;
        if (rd_vld)
            sum_next = sum + SUM_W'(rdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= 1'b0;
            sum    <= '0;
        end else begin
            rd_vld <= rd;
            sum    <= clear ? '0 : sum_next;
        end
    end

endmodule

// File: rtl/sum_job_responder.sv
// start/done job responder: reads N_WORDS words, writes their sum, pulses done.
// Optional START_QUEUE_EN: a start seen while busy is held and run right after done.
module sum_job_responder
    import sum_job_pkg::*;
#(
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RES_W   = res_width(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              res_wr,
    output logic [RES_W-1:0]  res_data
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              clear;
    logic              rerun;
    logic [RES_W-1:0]  acc_next;

`ifdef START_QUEUE_EN
    logic pending;

    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (state == ST_DONE)
            pending <= 1'b0;
        else if (busy && start)
            pending <= 1'b1;
    end

    // A start arriving in the DONE cycle itself is honoured as well.
    assign rerun = pending | start;
`else
    assign rerun = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        busy      = 1'b1;
        mem_rd    = 1'b0;
        res_wr    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd = 1'b1;
                if (addr == ADDR_W'(N_WORDS - 1))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_WRITE;
            ST_WRITE: begin
                res_wr    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (rerun) begin
                    clear     = 1'b1;
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            res_data <= '0;
        end else begin
            state <= state_nxt;
            if (clear)
                addr <= '0;
            else if (mem_rd)
                addr <= addr + ADDR_W'(1);
            // Capture includes the last word, which lands on this same edge.
            if (state == ST_DRAIN)
                res_data <= acc_next;
        end
    end

    word_accumulator #(
        .DATA_W (DATA_W),
        .SUM_W  (RES_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .rd       (mem_rd),
        .rdata    (mem_rdata),
        .sum_next (acc_next)
    );

endmodule

// File: tb/tb_sum_job_responder.sv
// Scoreboard bench for sum_job_responder; follows START_QUEUE_EN when defined.
module tb_sum_job_responder;

    localparam int NW = 16;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          done, busy, mem_rd, res_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [RW-1:0] res_data;

    logic [DW-1:0] mem [NW];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] res_q[$];
    int            done_q[$];
    int            rdc_q[$];
    logic [AW-1:0] addr_q[$];

    sum_job_responder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .res_wr    (res_wr),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd)
            mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (res_wr) res_q.push_back(res_data);
        if (done) done_q.push_back(cyc);
        if (mem_rd) begin
            addr_q.push_back(mem_addr);
            rdc_q.push_back(cyc);
        end
    end

    function automatic logic [RW-1:0] mem_sum();
        logic [RW-1:0] s = '0;
        for (int i = 0; i < NW; i++) s += RW'(mem[i]);
        return s;
    endfunction

    task automatic clear_logs();
        exp_q.delete(); res_q.delete(); done_q.delete(); rdc_q.delete(); addr_q.delete();
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < NW; i++)
            case (mode)
                0: mem[i] = DW'(i + 1);
                1: mem[i] = 16'hFFFF;
                2: mem[i] = 16'h0000;
                default: mem[i] = DW'($urandom);
            endcase
    endtask

    task automatic issue_start(output int e0);
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(mem_sum());
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (done_q.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: done pulses %0d, required %0d", name, done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({done, busy, mem_rd, res_wr, mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: done/busy/rd/wr/addr=%b, required 0", {done, busy, mem_rd, res_wr, mem_addr});
        end
        n_cmp++;
        if (res_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res_data=%h, required 0", res_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e0;
        bit ok;
        clear_logs(); fill_mem(0);
        issue_start(e0);
        wait_done(1, 40, "basic");
        ok = (addr_q.size() == NW);
        for (int i = 0; i < NW && ok; i++)
            if (addr_q[i] !== AW'(i) || rdc_q[i] != e0 + i) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_addr: %0d reads, first at cyc %0d, required 16 in order from cyc %0d",
                     addr_q.size(), rdc_q.size() ? rdc_q[0] : -1, e0);
        end
        n_cmp++;
        if (res_q.size() != 1 || res_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL basic_sum: %0d writes, got %h, required %h", res_q.size(), res_q.size() ? res_q[0] : '0, exp_q[0]);
        end
        n_cmp++;
        if (done_q.size() == 0 || done_q[0] - e0 != 18) begin
            n_fail++;
            $display("FAIL basic_latency: done at +%0d, required +18", done_q.size() ? done_q[0] - e0 : -1);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b, required 0", busy);
        end
        n_cmp++;
        if (res_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL basic_hold: res_data=%h, required %h", res_data, exp_q[0]);
        end
    endtask

    task automatic test_values();
        int e0;
        int modes[3] = '{1, 2, 3};
        foreach (modes[m]) begin
            clear_logs(); fill_mem(modes[m]);
            issue_start(e0);
            wait_done(1, 40, "values");
            n_cmp++;
            if (res_q.size() != 1 || res_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL values_mode%0d: got %h, required %h", modes[m], res_q.size() ? res_q[0] : '0, exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        clear_logs(); fill_mem(3);
        issue_start(e0);
        exp_q.delete();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({done, busy, mem_rd, res_wr, mem_addr} !== '0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ctrl=%b res_data=%h, required all 0",
                     {done, busy, mem_rd, res_wr, mem_addr}, res_data);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (res_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_abort: %0d writes %0d dones, required 0 and 0", res_q.size(), done_q.size());
        end
        clear_logs(); fill_mem(0);
        issue_start(e0);
        wait_done(1, 40, "midreset_fresh");
        n_cmp++;
        if (res_q.size() != 1 || res_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midreset_fresh: got %h, required %h", res_q.size() ? res_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_start_hold();
        int nj;
        clear_logs(); fill_mem(3);
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(mem_sum());
        repeat (3) @(negedge clk);
        start = 1'b0;
`ifdef START_QUEUE_EN
        exp_q.push_back(mem_sum());
        nj = 2;
`else
        nj = 1;
`endif
        wait_done(nj, 80, "hold");
        repeat (25) @(negedge clk);
        #1;
        n_cmp++;
        if (done_q.size() != nj || res_q.size() != nj) begin
            n_fail++;
            $display("FAIL hold_jobs: %0d dones %0d writes, required %0d", done_q.size(), res_q.size(), nj);
        end
        n_cmp++;
        if (res_q.size() == 0 || res_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL hold_sum: got %h, required %h", res_q.size() ? res_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_queue();
        int e0;
        int nj;
        clear_logs(); fill_mem(3);
        issue_start(e0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
`ifdef START_QUEUE_EN
        exp_q.push_back(mem_sum());
        nj = 2;
`else
        nj = 1;
`endif
        wait_done(nj, 80, "queue");
        repeat (25) @(negedge clk);
        #1;
        n_cmp++;
        if (done_q.size() != nj || res_q.size() != nj) begin
            n_fail++;
            $display("FAIL queue_jobs: %0d dones %0d writes, required %0d", done_q.size(), res_q.size(), nj);
        end
        n_cmp++;
        if (rdc_q.size() != nj * NW) begin
            n_fail++;
            $display("FAIL queue_reads: %0d reads, required %0d", rdc_q.size(), nj * NW);
        end
`ifdef START_QUEUE_EN
        n_cmp++;
        if (rdc_q.size() <= NW || done_q.size() < 2 || rdc_q[NW] != done_q[0] + 1 || done_q[1] != e0 + 37) begin
            n_fail++;
            $display("FAIL queue_timing: second read cyc %0d, dones %0d/%0d, required %0d and %0d/%0d",
                     rdc_q.size() > NW ? rdc_q[NW] : -1, done_q.size() ? done_q[0] : -1,
                     done_q.size() > 1 ? done_q[1] : -1, e0 + 19, e0 + 18, e0 + 37);
        end
        n_cmp++;
        if (res_q.size() < 2 || res_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL queue_sum2: got %h, required %h", res_q.size() > 1 ? res_q[1] : '0, exp_q[1]);
        end
`endif
    endtask

    task automatic test_rst_start();
        clear_logs();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_now: busy=%b mem_rd=%b, required 0 0", busy, mem_rd);
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rdc_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_start_later: busy=%b reads=%0d, required 0 0", busy, rdc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_values();
        test_start_hold();
        test_queue();
        test_rst_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
